// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte FIFO sitting behind a UART receiver. A rising edge on the
//   receiver's data-available strobe writes one byte; the consumer drains bytes
//   with a valid/ready handshake (first-word-fall-through). Reports fill level,
//   empty/full/almost-full, and a sticky overflow flag for dropped bytes.
//
//   Ports
//     i_clock, i_reset_n       clock, async active-low reset
//     i_rx_valid, i_rx_byte    receiver strobe and byte (edge-detected)
//     i_rd_ready               consumer accepts head byte this cycle
//     o_rd_valid, o_rd_data    head byte available / head byte (8'h00 when empty)
//     o_count                  bytes stored, 0..DEPTH
//     o_empty, o_full          count == 0 / count == DEPTH
//     o_almost_full            count >= ALMOST_FULL
//     o_overflow               sticky: a byte was dropped while full
//     i_clear_overflow         synchronous clear of o_overflow (a new drop wins)
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_rx_valid,
  input  logic [7:0]                 i_rx_byte,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [7:0]                 o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  input  logic                       i_clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rx_valid_q;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] count;
  logic          push, pop, wr_en, full, empty;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // and the difference is the fill level directly.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));

  always_comb begin
    push       = i_rx_valid & ~rx_valid_q;
    pop        = ~empty & i_rd_ready;
    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted in that case.
    wr_en      = push & (~full | pop);
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    // Set takes priority over clear.
    overflow_d = (push & full & ~pop) | (overflow_q & ~i_clear_overflow);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_valid_q <= i_rx_valid;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= i_rx_byte;
  end

  assign o_rd_valid    = ~empty;
  assign o_rd_data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign o_count       = count;
  assign o_empty       = empty;
  assign o_full        = full;
  assign o_almost_full = (count >= PW'(ALMOST_FULL));
  assign o_overflow    = overflow_q;

endmodule
